// File: rtl/efx_ram_rd_ctrl.sv
// Read side of a RAM-backed FIFO: fetches words behind the writer pointer and streams them out.
// Define EFX_RAM_RD_CTRL_LEVEL_EN to add the registered LEVEL (WPTR - RPTR) output.
module efx_ram_rd_ctrl #(
  parameter int READ_WIDTH = 20,
  parameter int ADDR_WIDTH = 8,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH:0]   WPTR,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic                  RE,
  input  logic [READ_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH:0]   RPTR,
  output logic [READ_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY
`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   LEVEL
`endif
);

  localparam int LAT   = 1 + OUTPUT_REG;
  localparam int DEPTH = LAT + 1;
  localparam int IW    = $clog2(DEPTH);
  localparam int OW    = 4;

  logic [ADDR_WIDTH:0]   fptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [LAT-1:0]        vld_p1;
  logic [LAT-1:0]        vld_p1_nxt;
  logic [OW-1:0]         count;
  logic [OW-1:0]         occ;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [READ_WIDTH-1:0] fifo_mem [2**IW];
  logic                  empty;
  logic                  push;
  logic                  pop;

  function automatic logic [OW-1:0] ones(input logic [LAT-1:0] v);
    logic [OW-1:0] n;
    n = '0;
    for (int i = 0; i < LAT; i++) n = n + {{(OW-1){1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  assign empty   = (fptr == WPTR);
  assign pop     = M_VALID & M_READY;
  assign push    = vld_p1[LAT-1];
  // A slot popped this cycle is free for a read issued now; this keeps full throughput.
  assign occ     = ones(vld_p1) + count - {{(OW-1){1'b0}}, pop};
  assign RE      = !empty && (occ < OW'(DEPTH));
  assign RADDR   = fptr[ADDR_WIDTH-1:0];
  assign RPTR    = rptr;
  assign M_VALID = (count != '0);
  assign M_DATA  = fifo_mem[rd_idx];

  always_comb begin
    vld_p1_nxt    = '0;
    vld_p1_nxt[0] = RE;
    for (int i = 1; i < LAT; i++) vld_p1_nxt[i] = vld_p1[i-1];
  end

  // Stage p0 -> p1: read issue, in-flight tracking and capture bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      fptr   <= '0;
      rptr   <= '0;
      vld_p1 <= '0;
      count  <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (RE)   fptr   <= fptr + 1'b1;
      if (pop)  rptr   <= rptr + 1'b1;
      vld_p1 <= vld_p1_nxt;
      if (push) wr_idx <= idx_inc(wr_idx);
      if (pop)  rd_idx <= idx_inc(rd_idx);
      count  <= count + {{(OW-1){1'b0}}, push} - {{(OW-1){1'b0}}, pop};
    end
  end

  // Stage p1 -> output: capture returning RAM data
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_idx] <= RDATA;
  end

`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
  always_ff @(posedge CLK) begin
    if (RST) LEVEL <= '0;
    else     LEVEL <= WPTR - rptr;
  end
`endif

endmodule

// File: tb/tb_efx_ram_rd_ctrl.sv
// Bench for efx_ram_rd_ctrl: one instance with RAM latency 1, one with latency 2, scoreboarded streams.
module tb_efx_ram_rd_ctrl;
  localparam int AW = 8;
  localparam int DW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [AW:0]   wptr0, wptr1, rptr0, rptr1;
  logic [AW-1:0] raddr0, raddr1;
  logic          re0, re1, m_valid0, m_valid1, m_ready0, m_ready1;
  logic [DW-1:0] m_data0, m_data1, rd0, rd1a, rd1b;
`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
  logic [AW:0]   level0, level1;
`endif

  logic [DW-1:0] ram [256];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [AW-1:0] addr_q [$];
  logic [AW-1:0] exp_addr [5];
  int vectors = 0;
  int miscompares = 0;
  logic st0 = 1'b0, st1 = 1'b0;
  logic [DW-1:0] hd0, hd1;

  efx_ram_rd_ctrl #(.READ_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(0)) u_l1 (
    .CLK(clk), .RST(rst), .WPTR(wptr0), .RADDR(raddr0), .RE(re0), .RDATA(rd0),
    .RPTR(rptr0), .M_DATA(m_data0), .M_VALID(m_valid0), .M_READY(m_ready0)
`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
    , .LEVEL(level0)
`endif
  );

  efx_ram_rd_ctrl #(.READ_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(1)) u_l2 (
    .CLK(clk), .RST(rst), .WPTR(wptr1), .RADDR(raddr1), .RE(re1), .RDATA(rd1b),
    .RPTR(rptr1), .M_DATA(m_data1), .M_VALID(m_valid1), .M_READY(m_ready1)
`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
    , .LEVEL(level1)
`endif
  );

  // RAM models: latency 1 for u_l1, latency 2 (output register) for u_l2
  always @(posedge clk) begin
    if (re0) rd0 <= ram[raddr0];
    if (re1) rd1a <= ram[raddr1];
    rd1b <= rd1a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitors: hold checks while stalled, scoreboard pop on each transfer
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      st0 = 1'b0;
      st1 = 1'b0;
    end else begin
      if (st0) begin
        check("hold_valid0", 32'(m_valid0), 32'd1);
        check("hold_data0", 32'(m_data0), 32'(hd0));
      end
      if (st1) begin
        check("hold_valid1", 32'(m_valid1), 32'd1);
        check("hold_data1", 32'(m_data1), 32'(hd1));
      end
      if (m_valid0 && m_ready0) begin
        e = (q0.size() != 0) ? q0.pop_front() : 'x;
        check("data0", 32'(m_data0), 32'(e));
      end
      if (m_valid1 && m_ready1) begin
        e = (q1.size() != 0) ? q1.pop_front() : 'x;
        check("data1", 32'(m_data1), 32'(e));
      end
      st0 = m_valid0 && !m_ready0;
      hd0 = m_data0;
      st1 = m_valid1 && !m_ready1;
      hd1 = m_data1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain0(input int bound);
    int n = 0;
    while (q0.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain0", 32'(q0.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic drain1(input int bound);
    int n = 0;
    while (q1.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain1", 32'(q1.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int rc;
    for (int i = 0; i < 256; i++) ram[i] = 20'($urandom);
    ram[0] = 20'h5A5A5;
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    rst = 1'b1; wptr0 = '0; wptr1 = '0; m_ready0 = 1'b0; m_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_re0", 32'(re0), 32'd0);
    check("rst_valid0", 32'(m_valid0), 32'd0);
    check("rst_raddr0", 32'(raddr0), 32'd0);
    check("rst_rptr0", 32'(rptr0), 32'd0);
    check("rst_re1", 32'(re1), 32'd0);
    check("rst_valid1", 32'(m_valid1), 32'd0);
    check("rst_raddr1", 32'(raddr1), 32'd0);
    check("rst_rptr1", 32'(rptr1), 32'd0);

    // Single word, latency 1
    step();
    m_ready0 = 1'b1; wptr0 = 9'd1; q0.push_back(ram[0]);
    @(negedge clk);
    check("a_re", 32'(re0), 32'd1);
    check("a_raddr", 32'(raddr0), 32'd0);
    @(negedge clk);
    check("a_valid_early", 32'(m_valid0), 32'd0);
    @(negedge clk);
    check("a_valid", 32'(m_valid0), 32'd1);
    check("a_data", 32'(m_data0), 32'h5A5A5);
    @(negedge clk);
    check("a_rptr", 32'(rptr0), 32'd1);
    check("a_valid_after", 32'(m_valid0), 32'd0);

    // Ten words back-to-back, latency 2
    step();
    m_ready1 = 1'b1; wptr1 = 9'd10;
    for (int i = 0; i < 10; i++) q1.push_back(ram[i]);
    n = 0;
    @(negedge clk);
    while (!m_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_first_latency", 32'(n), 32'd3);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check("b_no_gap", 32'(m_valid1), 32'd1);
    end
    @(negedge clk);
    check("b_valid_end", 32'(m_valid1), 32'd0);
    check("b_rptr", 32'(rptr1), 32'd10);

    // Stalled consumer: reads bounded by L+1, head held, order kept on release
    step();
    m_ready1 = 1'b0; wptr1 = 9'd15;
    for (int i = 10; i < 15; i++) q1.push_back(ram[i]);
    rc = 0;
    repeat (5) begin
      @(negedge clk);
      if (re1) rc++;
    end
    check("c_reads", 32'(rc), 32'd3);
    check("c_valid", 32'(m_valid1), 32'd1);
    check("c_head", 32'(m_data1), 32'(ram[10]));
    step();
    m_ready1 = 1'b1;
    drain1(40);
    check("c_rptr", 32'(rptr1), 32'd15);

    // Address wrap through 0xFF -> 0x00 with wrap bit toggling
    step();
    wptr0 = 9'h0FE;
    for (int i = 1; i < 'hFE; i++) q0.push_back(ram[i]);
    drain0(600);
    check("d_rptr_start", 32'(rptr0), 32'h0FE);
    step();
    wptr0 = 9'h103;
    for (int i = 0; i < 5; i++) q0.push_back(ram[exp_addr[i]]);
    repeat (10) begin
      @(negedge clk);
      if (re0) addr_q.push_back(raddr0);
    end
    check("d_read_count", 32'(addr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (addr_q.size() != 0) check("d_raddr", 32'(addr_q.pop_front()), 32'(exp_addr[i]));
    end
    drain0(20);
    check("d_rptr_end", 32'(rptr0), 32'h103);
    check("d_raddr_end", 32'(raddr0), 32'h03);

    // Reset with reads in flight: nothing emerges afterwards
    step();
    wptr0 = 9'h104; wptr1 = 9'd16;
    @(negedge clk);
    check("e_re0", 32'(re0), 32'd1);
    check("e_re1", 32'(re1), 32'd1);
    step();
    rst = 1'b1; wptr0 = '0; wptr1 = '0;
    q0.delete(); q1.delete();
    step();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("e_valid0", 32'(m_valid0), 32'd0);
      check("e_valid1", 32'(m_valid1), 32'd0);
    end
    check("e_rptr0", 32'(rptr0), 32'd0);
    check("e_rptr1", 32'(rptr1), 32'd0);
    check("e_raddr0", 32'(raddr0), 32'd0);

`ifdef EFX_RAM_RD_CTRL_LEVEL_EN
    step();
    wptr0 = 9'd2; q0.push_back(ram[0]); q0.push_back(ram[1]);
    drain0(20);
    check("f_rptr", 32'(rptr0), 32'd2);
    step();
    m_ready0 = 1'b0; wptr0 = 9'd5;
    q0.push_back(ram[2]); q0.push_back(ram[3]); q0.push_back(ram[4]);
    @(negedge clk);
    @(negedge clk);
    check("f_level", 32'(level0), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
